// File: rtl/genaxis_keep_gen.sv
// Per-packet AXI-Stream beat descriptor sequencer: tkeep, tlast and beat index per data beat.
// Latency: first descriptor one cycle after command accept; back-to-back packets chain with no bubble.
// Backpressure: descriptor held stable while m_ready low; cmd_ready only in IDLE or on the last-beat transfer.
module genaxis_keep_gen #(
  parameter int DATA_BYTES = 4,
  parameter int LEN_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [LEN_W-1:0]      cmd_len,
  input  logic                  cmd_align,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_BYTES-1:0] m_keep,
  output logic                  m_last,
  output logic [LEN_W-1:0]      m_beat,
  output logic                  zero_len_err
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [LEN_W-1:0]        remaining_q, remaining_d;
  logic                    align_q, align_d;
  logic [LEN_W-1:0]        beat_q, beat_d;
  logic                    zerr_q, zerr_d;

  logic                    run;
  logic [31:0]             rem32;
  logic [DATA_BYTES-1:0]   keep_c;
  logic                    last_c;
  logic                    xfer;
  logic                    last_xfer;
  logic                    accept;

  assign run   = (state_q == RUN);
  assign rem32 = 32'(remaining_q);

  // Byte-enable mask from registered remaining count and alignment only.
  always_comb begin
    keep_c = '0;
    if (rem32 >= 32'(DATA_BYTES)) begin
      keep_c = '1;
    end else begin
      for (int i = 0; i < DATA_BYTES; i++) begin
        if (align_q) begin
          // High-aligned partial beat: top 'remaining' lanes enabled.
          keep_c[i] = (32'(i) >= (32'(DATA_BYTES) - rem32));
        end else begin
          keep_c[i] = (32'(i) < rem32);
        end
      end
    end
  end

  assign last_c       = (rem32 <= 32'(DATA_BYTES));
  assign m_valid      = run;
  assign m_keep       = run ? keep_c : '0;
  assign m_last       = run & last_c;
  assign m_beat       = beat_q;
  assign zero_len_err = zerr_q;

  assign xfer      = m_valid & m_ready;
  assign last_xfer = xfer & m_last;
  // Ready on the last-beat transfer lets the next packet start with no idle cycle.
  assign cmd_ready = (state_q == IDLE) | last_xfer;
  assign accept    = cmd_valid & cmd_ready;

  // Next-state: advance beats, close packet on last transfer, then load a new command.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    align_d     = align_q;
    beat_d      = beat_q;
    zerr_d      = 1'b0;

    if (xfer) begin
      if (last_c) begin
        state_d     = IDLE;
        remaining_d = '0;
        align_d     = 1'b0;
        beat_d      = '0;
      end else begin
        remaining_d = remaining_q - LEN_W'(DATA_BYTES);
        beat_d      = beat_q + 1'b1;
      end
    end

    if (accept) begin
      if (cmd_len != '0) begin
        state_d     = RUN;
        remaining_d = cmd_len;
        align_d     = cmd_align;
        beat_d      = '0;
      end else begin
        // Zero-length packets produce no beats, only a one-cycle flag.
        zerr_d = 1'b1;
      end
    end
  end

  // State and datapath registers; reset abandons any packet in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      align_q     <= 1'b0;
      beat_q      <= '0;
      zerr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      align_q     <= align_d;
      beat_q      <= beat_d;
      zerr_q      <= zerr_d;
    end
  end

endmodule

// File: tb/tb_genaxis_keep_gen.sv
module tb_genaxis_keep_gen;

  localparam int DB = 4;
  localparam int LW = 16;

  logic          clk;
  logic          reset_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [LW-1:0] cmd_len;
  logic          cmd_align;
  logic          m_valid;
  logic          m_ready;
  logic [DB-1:0] m_keep;
  logic          m_last;
  logic [LW-1:0] m_beat;
  logic          zero_len_err;

  int checks;
  int failures;

  genaxis_keep_gen #(.DATA_BYTES(DB), .LEN_W(LW)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_len      (cmd_len),
    .cmd_align    (cmd_align),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_keep       (m_keep),
    .m_last       (m_last),
    .m_beat       (m_beat),
    .zero_len_err (zero_len_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++;
    if ({m_valid, m_keep, m_last, m_beat, zero_len_err} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got valid=%b keep=%b last=%b beat=%0d zerr=%b, want all zero",
               m_valid, m_keep, m_last, m_beat, zero_len_err);
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready);
    end
  endtask

  task automatic test_lsb_align();
    logic [DB-1:0] ek [3];
    ek[0] = 4'b1111; ek[1] = 4'b1111; ek[2] = 4'b0011;
    cmd_valid = 1'b1; cmd_len = 16'd10; cmd_align = 1'b0; m_ready = 1'b1;
    #1;
    checks++;
    if (m_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL lsb_accept_cycle: got valid=%b ready=%b want valid=0 ready=1", m_valid, cmd_ready);
    end
    tick();
    cmd_valid = 1'b0;
    for (int b = 0; b < 3; b++) begin
      #1;
      checks++;
      if (m_valid !== 1'b1 || m_keep !== ek[b] || m_last !== (b == 2) || m_beat !== LW'(b)
          || cmd_ready !== (b == 2)) begin
        failures++;
        $display("FAIL lsb_beat%0d: got valid=%b keep=%b last=%b beat=%0d rdy=%b want 1 %b %b %0d %b",
                 b, m_valid, m_keep, m_last, m_beat, cmd_ready, ek[b], (b == 2), b, (b == 2));
      end
      tick();
    end
    checks++;
    if (m_valid !== 1'b0) begin
      failures++;
      $display("FAIL lsb_end_idle: got valid=%b want 0", m_valid);
    end
  endtask

  task automatic test_msb_align();
    logic [DB-1:0] ek [3];
    ek[0] = 4'b1111; ek[1] = 4'b1111; ek[2] = 4'b1100;
    cmd_valid = 1'b1; cmd_len = 16'd10; cmd_align = 1'b1; m_ready = 1'b1;
    tick();
    cmd_valid = 1'b0;
    for (int b = 0; b < 3; b++) begin
      checks++;
      if (m_valid !== 1'b1 || m_keep !== ek[b] || m_last !== (b == 2) || m_beat !== LW'(b)) begin
        failures++;
        $display("FAIL msb_beat%0d: got valid=%b keep=%b last=%b beat=%0d want 1 %b %b %0d",
                 b, m_valid, m_keep, m_last, m_beat, ek[b], (b == 2), b);
      end
      tick();
    end
    cmd_valid = 1'b1; cmd_len = 16'd4; cmd_align = 1'b0;
    tick();
    cmd_valid = 1'b0;
    checks++;
    if (m_valid !== 1'b1 || m_keep !== 4'b1111 || m_last !== 1'b1 || m_beat !== 16'd0) begin
      failures++;
      $display("FAIL len4_single: got valid=%b keep=%b last=%b beat=%0d want 1 1111 1 0",
               m_valid, m_keep, m_last, m_beat);
    end
    tick();
    checks++;
    if (m_valid !== 1'b0) begin
      failures++;
      $display("FAIL len4_end: got valid=%b want 0", m_valid);
    end
  endtask

  task automatic test_zero_len();
    cmd_valid = 1'b1; cmd_len = 16'd0; cmd_align = 1'b0; m_ready = 1'b1;
    tick();
    cmd_valid = 1'b0;
    checks++;
    if (zero_len_err !== 1'b1 || m_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL zero_len_pulse: got zerr=%b valid=%b rdy=%b want 1 0 1",
               zero_len_err, m_valid, cmd_ready);
    end
    tick();
    checks++;
    if (zero_len_err !== 1'b0 || m_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL zero_len_after: got zerr=%b valid=%b rdy=%b want 0 0 1",
               zero_len_err, m_valid, cmd_ready);
    end
  endtask

  task automatic test_back_to_back();
    cmd_valid = 1'b1; cmd_len = 16'd5; cmd_align = 1'b0; m_ready = 1'b1;
    tick();
    cmd_len = 16'd3;
    #1;
    checks++;
    if (m_keep !== 4'b1111 || m_last !== 1'b0 || m_beat !== 16'd0 || cmd_ready !== 1'b0) begin
      failures++;
      $display("FAIL b2b_a0: got keep=%b last=%b beat=%0d rdy=%b want 1111 0 0 0",
               m_keep, m_last, m_beat, cmd_ready);
    end
    tick();
    checks++;
    if (m_keep !== 4'b0001 || m_last !== 1'b1 || m_beat !== 16'd1 || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_a1: got keep=%b last=%b beat=%0d rdy=%b want 0001 1 1 1",
               m_keep, m_last, m_beat, cmd_ready);
    end
    tick();
    cmd_valid = 1'b0;
    checks++;
    if (m_valid !== 1'b1 || m_keep !== 4'b0111 || m_last !== 1'b1 || m_beat !== 16'd0) begin
      failures++;
      $display("FAIL b2b_b0: got valid=%b keep=%b last=%b beat=%0d want 1 0111 1 0",
               m_valid, m_keep, m_last, m_beat);
    end
    tick();
    checks++;
    if (m_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_end: got valid=%b want 0", m_valid);
    end
  endtask

  task automatic test_backpressure();
    logic          mr [5];
    logic [DB-1:0] ek [5];
    logic [LW-1:0] eb [5];
    mr[0] = 1; mr[1] = 0; mr[2] = 0; mr[3] = 1; mr[4] = 1;
    ek[0] = 4'b1111; ek[1] = 4'b1111; ek[2] = 4'b1111; ek[3] = 4'b1111; ek[4] = 4'b0001;
    eb[0] = 0; eb[1] = 1; eb[2] = 1; eb[3] = 1; eb[4] = 2;
    cmd_valid = 1'b1; cmd_len = 16'd9; cmd_align = 1'b0; m_ready = 1'b1;
    tick();
    cmd_len = 16'd0;
    cmd_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      m_ready = mr[c];
      #1;
      checks++;
      if (m_valid !== 1'b1 || m_keep !== ek[c] || m_beat !== eb[c] || m_last !== (c == 4)
          || cmd_ready !== (c == 4)) begin
        failures++;
        $display("FAIL bp_cycle%0d: got valid=%b keep=%b beat=%0d last=%b rdy=%b want 1 %b %0d %b %b",
                 c, m_valid, m_keep, m_beat, m_last, cmd_ready, ek[c], eb[c], (c == 4), (c == 4));
      end
      tick();
    end
    m_ready = 1'b1;
    checks++;
    if (m_valid !== 1'b0 || zero_len_err !== 1'b0) begin
      failures++;
      $display("FAIL bp_end: got valid=%b zerr=%b want 0 0", m_valid, zero_len_err);
    end
  endtask

  task automatic test_reset_mid_packet();
    cmd_valid = 1'b1; cmd_len = 16'd12; cmd_align = 1'b0; m_ready = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    checks++;
    if (m_valid !== 1'b1 || m_beat !== 16'd1) begin
      failures++;
      $display("FAIL rst_pre: got valid=%b beat=%0d want 1 1", m_valid, m_beat);
    end
    #1;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({m_valid, m_keep, m_last, m_beat, zero_len_err} !== '0) begin
      failures++;
      $display("FAIL rst_async: got valid=%b keep=%b last=%b beat=%0d zerr=%b want all zero",
               m_valid, m_keep, m_last, m_beat, zero_len_err);
    end
    tick();
    #2;
    reset_n = 1'b1;
    tick();
    checks++;
    if (m_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_release: got valid=%b rdy=%b want 0 1", m_valid, cmd_ready);
    end
    tick();
    checks++;
    if (m_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_no_stale: got valid=%b want 0", m_valid);
    end
    cmd_valid = 1'b1; cmd_len = 16'd2; cmd_align = 1'b0;
    tick();
    cmd_valid = 1'b0;
    checks++;
    if (m_valid !== 1'b1 || m_keep !== 4'b0011 || m_last !== 1'b1 || m_beat !== 16'd0) begin
      failures++;
      $display("FAIL rst_new_pkt: got valid=%b keep=%b last=%b beat=%0d want 1 0011 1 0",
               m_valid, m_keep, m_last, m_beat);
    end
    tick();
    checks++;
    if (m_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_new_end: got valid=%b want 0", m_valid);
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_len   = '0;
    cmd_align = 1'b0;
    m_ready   = 1'b0;
    #2;
    test_reset();
    tick();
    tick();
    #2;
    reset_n = 1'b1;
    tick();
    test_lsb_align();
    test_msb_align();
    test_zero_len();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_packet();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
